ppi_lane_merger: RTL and testbench

- Receive-side counterpart of the DSI lane manager.
- Accepts byte beats on 1–4 PPI data lanes, merges them back into the original lane0-first byte order and parses DSI packets.
- Outputs decoded headers, packed payload words and per-packet status: CRC check and truncation.
- Sits between the PPI receive interface and the packet/register consumer in the loopback test environment.

---
 rtl/ppi_lane_merger_if.sv | 38 +++
 rtl/ppi_lane_merger.sv | 223 ++++++++++++++++++++++
 tb/tb_ppi_lane_merger.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ppi_lane_merger_if.sv
// PPI receive bundle: lane bytes in, decoded DSI headers, payload and status out.
interface ppi_lane_merger_if;
    logic [1:0]  lane_cfg;
    logic        ppi_valid;
    logic [7:0]  ppi_data_lane0;
    logic [7:0]  ppi_data_lane1;
    logic [7:0]  ppi_data_lane2;
    logic [7:0]  ppi_data_lane3;
    logic        hdr_valid;
    logic [7:0]  hdr_di;
    logic [15:0] hdr_wc;
    logic [7:0]  hdr_ecc;
    logic        pl_valid;
    logic [31:0] pl_data;
    logic [2:0]  pl_cnt;
    logic        pkt_done;
    logic        crc_err;
    logic        trunc_err;
    logic        wc_err;

    // PPI source side
    modport master (
        output lane_cfg, ppi_valid,
        output ppi_data_lane0, ppi_data_lane1, ppi_data_lane2, ppi_data_lane3,
        input  hdr_valid, hdr_di, hdr_wc, hdr_ecc,
        input  pl_valid, pl_data, pl_cnt,
        input  pkt_done, crc_err, trunc_err, wc_err
    );

    // Lane merger side
    modport slave (
        input  lane_cfg, ppi_valid,
        input  ppi_data_lane0, ppi_data_lane1, ppi_data_lane2, ppi_data_lane3,
        output hdr_valid, hdr_di, hdr_wc, hdr_ecc,
        output pl_valid, pl_data, pl_cnt,
        output pkt_done, crc_err, trunc_err, wc_err
    );
endinterface

// File: rtl/ppi_lane_merger.sv
// Merges 1-4 PPI receive lanes back into lane0-first byte order and parses
// DSI packets: header decode, packed payload, CRC-16 check and truncation.
// Every byte of a beat is consumed in its arrival cycle; outputs are registered.
module ppi_lane_merger #(
    parameter logic [15:0] MAX_WC = 16'hFFFF
) (
    input  logic dsi_clk,
    input  logic rst,
    ppi_lane_merger_if.slave bus
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_HDR     = 3'd1;
    localparam logic [2:0] ST_PAYLOAD = 3'd2;
    localparam logic [2:0] ST_CRC     = 3'd3;
    localparam logic [2:0] ST_PAD     = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [2:0]  n_q, n_d;
    logic [1:0]  hidx_q, hidx_d;
    logic        cidx_q, cidx_d;
    logic [7:0]  di_q, di_d;
    logic [15:0] wc_q, wc_d;
    logic [15:0] rem_q, rem_d;
    logic [15:0] crc_q, crc_d;
    logic [7:0]  crc_lo_q, crc_lo_d;

    logic        hdr_valid_q, hdr_valid_d;
    logic [7:0]  hdr_di_q, hdr_di_d;
    logic [15:0] hdr_wc_q, hdr_wc_d;
    logic [7:0]  hdr_ecc_q, hdr_ecc_d;
    logic        pl_valid_q, pl_valid_d;
    logic [31:0] pl_data_q, pl_data_d;
    logic [2:0]  pl_cnt_q, pl_cnt_d;
    logic        pkt_done_q, pkt_done_d;
    logic        crc_err_q, crc_err_d;
    logic        trunc_err_q, trunc_err_d;
    logic        wc_err_q, wc_err_d;

    logic [7:0]  lane_b [4];

    // Reflected CRC-16-CCITT (poly 0x1021 reversed = 0x8408), one byte LSB-first
    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int k = 0; k < 8; k++) begin
            r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
        end
        return r;
    endfunction

    // DSI long-packet data types; everything else is a short packet
    function automatic logic is_long(input logic [7:0] d);
        case (d[5:0])
            6'h09, 6'h19, 6'h29, 6'h39, 6'h0E, 6'h1E, 6'h2E, 6'h3E: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    assign lane_b[0] = bus.ppi_data_lane0;
    assign lane_b[1] = bus.ppi_data_lane1;
    assign lane_b[2] = bus.ppi_data_lane2;
    assign lane_b[3] = bus.ppi_data_lane3;

    // Walk the active lanes of this beat in order, advancing the packet parser per byte
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        hidx_d      = hidx_q;
        cidx_d      = cidx_q;
        di_d        = di_q;
        wc_d        = wc_q;
        rem_d       = rem_q;
        crc_d       = crc_q;
        crc_lo_d    = crc_lo_q;
        hdr_valid_d = 1'b0;
        hdr_di_d    = 8'h00;
        hdr_wc_d    = 16'h0000;
        hdr_ecc_d   = 8'h00;
        pl_data_d   = 32'h0;
        pl_cnt_d    = 3'd0;
        pkt_done_d  = 1'b0;
        crc_err_d   = 1'b0;
        trunc_err_d = 1'b0;
        wc_err_d    = 1'b0;

        if (bus.ppi_valid) begin
            // Lane count is fixed for the whole burst at its first beat
            if (state_d == ST_IDLE) begin
                n_d     = {1'b0, bus.lane_cfg} + 3'd1;
                state_d = ST_HDR;
                hidx_d  = 2'd0;
            end
            for (int i = 0; i < 4; i++) begin
                if (3'(i) < n_d) begin
                    case (state_d)
                        ST_HDR: begin
                            case (hidx_d)
                                2'd0:    di_d       = lane_b[i[1:0]];
                                2'd1:    wc_d[7:0]  = lane_b[i[1:0]];
                                2'd2:    wc_d[15:8] = lane_b[i[1:0]];
                                default: begin
                                    hdr_valid_d = 1'b1;
                                    hdr_di_d    = di_d;
                                    hdr_wc_d    = wc_d;
                                    hdr_ecc_d   = lane_b[i[1:0]];
                                    if (!is_long(di_d)) begin
                                        pkt_done_d = 1'b1;
                                        state_d    = ST_PAD;
                                    end else begin
                                        wc_err_d = (wc_d > MAX_WC);
                                        crc_d    = 16'hFFFF;
                                        rem_d    = wc_d;
                                        cidx_d   = 1'b0;
                                        state_d  = (wc_d == 16'h0000) ? ST_CRC : ST_PAYLOAD;
                                    end
                                end
                            endcase
                            hidx_d = hidx_d + 2'd1;
                        end
                        ST_PAYLOAD: begin
                            pl_data_d[{pl_cnt_d[1:0], 3'b000} +: 8] = lane_b[i[1:0]];
                            pl_cnt_d = pl_cnt_d + 3'd1;
                            crc_d    = crc_byte(crc_d, lane_b[i[1:0]]);
                            rem_d    = rem_d - 16'd1;
                            if (rem_d == 16'h0000) begin
                                state_d = ST_CRC;
                            end
                        end
                        ST_CRC: begin
                            if (!cidx_d) begin
                                crc_lo_d = lane_b[i[1:0]];
                                cidx_d   = 1'b1;
                            end else begin
                                crc_err_d  = ({lane_b[i[1:0]], crc_lo_d} != crc_d);
                                pkt_done_d = 1'b1;
                                cidx_d     = 1'b0;
                                state_d    = ST_PAD;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            // Remaining bytes of a finished packet's beat are padding; next beat is a new header
            if (state_d == ST_PAD) begin
                state_d = ST_HDR;
                hidx_d  = 2'd0;
            end
        end else begin
            // Burst ended: flag a packet that had started but not finished
            if ((state_d == ST_HDR && hidx_d != 2'd0) ||
                state_d == ST_PAYLOAD || state_d == ST_CRC) begin
                pkt_done_d  = 1'b1;
                trunc_err_d = 1'b1;
            end
            state_d = ST_IDLE;
            hidx_d  = 2'd0;
            cidx_d  = 1'b0;
        end
        pl_valid_d = (pl_cnt_d != 3'd0);
    end

    // Parser state and registered outputs
    always_ff @(posedge dsi_clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            n_q         <= 3'd0;
            hidx_q      <= 2'd0;
            cidx_q      <= 1'b0;
            di_q        <= 8'h00;
            wc_q        <= 16'h0000;
            rem_q       <= 16'h0000;
            crc_q       <= 16'h0000;
            crc_lo_q    <= 8'h00;
            hdr_valid_q <= 1'b0;
            hdr_di_q    <= 8'h00;
            hdr_wc_q    <= 16'h0000;
            hdr_ecc_q   <= 8'h00;
            pl_valid_q  <= 1'b0;
            pl_data_q   <= 32'h0;
            pl_cnt_q    <= 3'd0;
            pkt_done_q  <= 1'b0;
            crc_err_q   <= 1'b0;
            trunc_err_q <= 1'b0;
            wc_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            hidx_q      <= hidx_d;
            cidx_q      <= cidx_d;
            di_q        <= di_d;
            wc_q        <= wc_d;
            rem_q       <= rem_d;
            crc_q       <= crc_d;
            crc_lo_q    <= crc_lo_d;
            hdr_valid_q <= hdr_valid_d;
            hdr_di_q    <= hdr_di_d;
            hdr_wc_q    <= hdr_wc_d;
            hdr_ecc_q   <= hdr_ecc_d;
            pl_valid_q  <= pl_valid_d;
            pl_data_q   <= pl_data_d;
            pl_cnt_q    <= pl_cnt_d;
            pkt_done_q  <= pkt_done_d;
            crc_err_q   <= crc_err_d;
            trunc_err_q <= trunc_err_d;
            wc_err_q    <= wc_err_d;
        end
    end

    assign bus.hdr_valid = hdr_valid_q;
    assign bus.hdr_di    = hdr_di_q;
    assign bus.hdr_wc    = hdr_wc_q;
    assign bus.hdr_ecc   = hdr_ecc_q;
    assign bus.pl_valid  = pl_valid_q;
    assign bus.pl_data   = pl_data_q;
    assign bus.pl_cnt    = pl_cnt_q;
    assign bus.pkt_done  = pkt_done_q;
    assign bus.crc_err   = crc_err_q;
    assign bus.trunc_err = trunc_err_q;
    assign bus.wc_err    = wc_err_q;

endmodule

// File: tb/tb_ppi_lane_merger.sv
// Bench for ppi_lane_merger: packets are laid out as byte streams, expected
// per-beat outputs are derived from byte offsets, and a monitor compares
// every cycle's registered outputs against the queued expectation.
module tb_ppi_lane_merger;

    localparam logic [15:0] MAXWC = 16'h0100;

    logic dsi_clk = 1'b0;
    logic rst;

    ppi_lane_merger_if bus();

    ppi_lane_merger #(.MAX_WC(MAXWC)) dut (
        .dsi_clk (dsi_clk),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 dsi_clk = ~dsi_clk;

    typedef struct packed {
        logic        hv;
        logic [7:0]  di;
        logic [15:0] wc;
        logic [7:0]  ecc;
        logic        plv;
        logic [31:0] pd;
        logic [2:0]  pc;
        logic        done;
        logic        crc_e;
        logic        tr_e;
        logic        wc_e;
    } out_t;

    out_t       expq[$];
    out_t       bexp[$];
    logic [7:0] sbytes[$];
    int         pstart[$];
    int         cur_n;
    int         n_checks = 0;
    int         n_pass = 0;
    out_t       e_m, a_m;
    logic [5:0] long_dt [8] = '{6'h09, 6'h19, 6'h29, 6'h39, 6'h0E, 6'h1E, 6'h2E, 6'h3E};

    function automatic bit ref_long(input logic [7:0] d);
        foreach (long_dt[k]) if (long_dt[k] == d[5:0]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic start_burst(input int n);
        sbytes.delete();
        bexp.delete();
        pstart.delete();
        cur_n = n;
    endtask

    // Append one packet to the current burst and fill in the expected beat outputs
    task automatic add_pkt(input logic [7:0] di, input logic [15:0] wc, input logic [7:0] ecc,
                           input bit inc_pl, input bit bad_crc);
        int b0, len, nbeats, bb, idx;
        bit lng;
        logic [15:0] c;
        logic [7:0] by;
        bit fb;
        out_t e;
        b0 = sbytes.size() / cur_n;
        pstart.push_back(b0);
        lng = ref_long(di);
        sbytes.push_back(di);
        sbytes.push_back(wc[7:0]);
        sbytes.push_back(wc[15:8]);
        sbytes.push_back(ecc);
        len = lng ? 4 + int'(wc) + 2 : 4;
        nbeats = (len + cur_n - 1) / cur_n;
        for (int j = 0; j < nbeats; j++) bexp.push_back('0);
        e = bexp[b0 + 3 / cur_n];
        e.hv = 1'b1; e.di = di; e.wc = wc; e.ecc = ecc;
        if (!lng) e.done = 1'b1;
        else e.wc_e = (wc > MAXWC);
        bexp[b0 + 3 / cur_n] = e;
        if (lng) begin
            c = 16'hFFFF;
            for (int k = 0; k < int'(wc); k++) begin
                by = inc_pl ? 8'(k + 1) : 8'($urandom);
                sbytes.push_back(by);
                bb = b0 + (4 + k) / cur_n;
                e = bexp[bb];
                idx = int'(e.pc);
                e.pd[idx*8 +: 8] = by;
                e.pc = e.pc + 3'd1;
                e.plv = 1'b1;
                bexp[bb] = e;
                for (int t = 0; t < 8; t++) begin
                    fb = c[0] ^ by[t];
                    c = c >> 1;
                    if (fb) c = c ^ 16'h8408;
                end
            end
            sbytes.push_back(c[7:0] ^ {7'b0, bad_crc});
            sbytes.push_back(c[15:8]);
            bb = b0 + (len - 1) / cur_n;
            e = bexp[bb];
            e.done = 1'b1;
            e.crc_e = bad_crc;
            bexp[bb] = e;
        end
        while (sbytes.size() % cur_n != 0) sbytes.push_back(8'($urandom));
    endtask

    task automatic drive(input bit r, input bit v, input logic [1:0] cfg,
                         input logic [31:0] d, input out_t e);
        @(negedge dsi_clk);
        rst = r;
        bus.ppi_valid = v;
        bus.lane_cfg = cfg;
        bus.ppi_data_lane0 = d[7:0];
        bus.ppi_data_lane1 = d[15:8];
        bus.ppi_data_lane2 = d[23:16];
        bus.ppi_data_lane3 = d[31:24];
        expq.push_back(e);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) drive(1'b0, 1'b0, 2'($urandom), $urandom, '0);
    endtask

    // Send the first tbeats beats (all when negative); optionally cut with a reset cycle
    task automatic run_burst(input int tbeats, input bit rst_cut);
        int total, nb;
        bit at_boundary;
        logic [31:0] d;
        logic [1:0] cfg;
        out_t e;
        total = bexp.size();
        nb = (tbeats < 0) ? total : tbeats;
        for (int b = 0; b < nb; b++) begin
            d = $urandom;
            for (int l = 0; l < cur_n; l++) d[8*l +: 8] = sbytes[b*cur_n + l];
            cfg = (b == 0) ? 2'(cur_n - 1) : 2'($urandom);
            drive(1'b0, 1'b1, cfg, d, bexp[b]);
        end
        if (rst_cut) begin
            drive(1'b1, 1'b1, 2'($urandom), $urandom, '0);
        end else begin
            e = '0;
            at_boundary = 1'b0;
            foreach (pstart[k]) if (pstart[k] == nb) at_boundary = 1'b1;
            if (nb < total && !at_boundary) begin
                e.done = 1'b1;
                e.tr_e = 1'b1;
            end
            drive(1'b0, 1'b0, 2'($urandom), $urandom, e);
        end
    endtask

    // Monitor: one comparison per driven cycle, just after the active edge
    always @(posedge dsi_clk) begin
        #1;
        if (expq.size() != 0) begin
            e_m = expq.pop_front();
            a_m.hv = bus.hdr_valid;  a_m.di = bus.hdr_di;   a_m.wc = bus.hdr_wc;
            a_m.ecc = bus.hdr_ecc;   a_m.plv = bus.pl_valid; a_m.pd = bus.pl_data;
            a_m.pc = bus.pl_cnt;     a_m.done = bus.pkt_done; a_m.crc_e = bus.crc_err;
            a_m.tr_e = bus.trunc_err; a_m.wc_e = bus.wc_err;
            n_checks++;
            if (a_m === e_m) n_pass++;
            else $display("FAIL outputs t=%0t actual=%h required=%h (hv,di,wc,ecc,plv,pd,pc,done,crc,tr,wc_e)",
                          $time, a_m, e_m);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1);
    end

    initial begin
        int n, np, total, t;
        logic [7:0] di;
        logic [15:0] wc;
        rst = 1'b1;
        bus.ppi_valid = 1'b0;
        bus.lane_cfg = 2'd0;
        bus.ppi_data_lane0 = 8'h00;
        bus.ppi_data_lane1 = 8'h00;
        bus.ppi_data_lane2 = 8'h00;
        bus.ppi_data_lane3 = 8'h00;
        drive(1'b1, 1'b0, 2'd0, 32'h0, '0);
        drive(1'b1, 1'b0, 2'd0, 32'h0, '0);
        idle(2);

        // Short packet on 4 lanes
        start_burst(4); add_pkt(8'h05, 16'h0011, 8'h2C, 1'b1, 1'b0); run_burst(-1, 1'b0); idle(2);
        // Zero-length long packet on 1 lane
        start_burst(1); add_pkt(8'h39, 16'h0000, 8'h5A, 1'b1, 1'b0); run_burst(-1, 1'b0); idle(2);
        // WC=6 on 3 lanes, good and corrupted checksum
        start_burst(3); add_pkt(8'h29, 16'd6, 8'h11, 1'b1, 1'b0); run_burst(-1, 1'b0); idle(2);
        start_burst(3); add_pkt(8'h29, 16'd6, 8'h11, 1'b1, 1'b1); run_burst(-1, 1'b0); idle(2);
        // Truncation after two payload beats on 2 lanes, then a clean short packet
        start_burst(2); add_pkt(8'h39, 16'd8, 8'h22, 1'b1, 1'b0); run_burst(4, 1'b0); idle(1);
        start_burst(2); add_pkt(8'h05, 16'h1234, 8'h33, 1'b1, 1'b0); run_burst(-1, 1'b0); idle(2);
        // Reset mid-payload on 4 lanes, then a clean short packet
        start_burst(4); add_pkt(8'h39, 16'd40, 8'h44, 1'b0, 1'b0); run_burst(3, 1'b1); idle(1);
        start_burst(4); add_pkt(8'h15, 16'hBEEF, 8'h55, 1'b1, 1'b0); run_burst(-1, 1'b0); idle(2);
        // Back-to-back packets; WC=1 on 4 lanes puts payload, CRC and pad in one beat
        start_burst(4);
        add_pkt(8'h39, 16'd1, 8'h01, 1'b1, 1'b0);
        add_pkt(8'h05, 16'h0102, 8'h02, 1'b1, 1'b0);
        add_pkt(8'h09, 16'd0, 8'h03, 1'b1, 1'b0);
        add_pkt(8'h29, 16'd5, 8'h04, 1'b0, 1'b0);
        run_burst(-1, 1'b0); idle(2);
        // Word count around the MAX_WC limit
        start_burst(4); add_pkt(8'h29, 16'h0101, 8'h66, 1'b0, 1'b0); run_burst(-1, 1'b0); idle(1);
        start_burst(4); add_pkt(8'h29, 16'h0100, 8'h77, 1'b0, 1'b0); run_burst(-1, 1'b0); idle(2);

        // Randomized bursts
        for (int r = 0; r < 60; r++) begin
            n = $urandom_range(1, 4);
            start_burst(n);
            np = $urandom_range(1, 3);
            for (int p = 0; p < np; p++) begin
                if ($urandom_range(0, 1) == 1) begin
                    di = {2'($urandom), long_dt[$urandom_range(0, 7)]};
                    wc = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(16'hF8, 16'h110))
                                                     : 16'($urandom_range(0, 20));
                end else begin
                    di = 8'($urandom);
                    while (ref_long(di)) di = 8'($urandom);
                    wc = 16'($urandom);
                end
                add_pkt(di, wc, 8'($urandom), 1'b0, ($urandom_range(0, 3) == 0));
            end
            total = bexp.size();
            if ($urandom_range(0, 3) == 0 && total > 1) begin
                t = $urandom_range(1, total - 1);
                run_burst(t, ($urandom_range(0, 2) == 0));
            end else begin
                run_burst(-1, 1'b0);
            end
            idle($urandom_range(1, 3));
        end

        idle(3);
        @(posedge dsi_clk);
        #2;
        n_checks++;
        if (expq.size() == 0) n_pass++;
        else $display("FAIL drain: actual=%0d pending required=0", expq.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
